// File: rtl/shf_arb_pkg.sv
// ============================================================================
// Module : shf_arb_pkg
// Brief  : Shared defaults and request/response record types for the
//          shifter-sharing round-robin arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shf_arb_pkg;

    // Default configuration of the arbiter.
    localparam int NUM_REQ    = 4;
    localparam int SIZE_DATA  = 32;
    localparam int SIZE_SHIFT = 5;

    // Request as captured into the S1 stage (default-configuration view).
    typedef struct packed {
        logic [SIZE_DATA-1:0]       data;
        logic [SIZE_SHIFT-1:0]      shift;
        logic [$clog2(NUM_REQ)-1:0] id;
    } shf_req_t;

    // Response as held in the S2 stage (default-configuration view).
    typedef struct packed {
        logic [SIZE_DATA-1:0]       data;
        logic                       sticky;
        logic [$clog2(NUM_REQ)-1:0] id;
    } shf_rsp_t;

endpackage

`default_nettype wire

// File: rtl/SHF_right.sv
// ============================================================================
// Module : SHF_right
// Brief  : Combinational logical right barrel shifter, zero-filled.
//          Shift amounts at or beyond the operand width yield zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module SHF_right #(
    parameter int SIZE_DATA  = 32,
    parameter int SIZE_SHIFT = 5
) (
    input  logic [SIZE_DATA-1:0]  i_data,
    input  logic [SIZE_SHIFT-1:0] i_shift,
    output logic [SIZE_DATA-1:0]  o_data
);

    // Logical shift; oversized amounts naturally produce all zeros.
    assign o_data = i_data >> i_shift;

endmodule

`default_nettype wire

// File: rtl/shf_rr_arbiter.sv
// ============================================================================
// Module : shf_rr_arbiter
// Brief  : Round-robin arbiter sharing one right barrel shifter between
//          NUM_REQ requesters. Two-stage pipeline: S1 captures the granted
//          operand, S2 holds the shifted result for the single consumer.
// Config : SHF_ARB_STICKY_EN - when defined, o_rsp_sticky reports the OR of
//          all bits shifted out; otherwise it is tied to 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shf_rr_arbiter #(
    parameter int NUM_REQ    = shf_arb_pkg::NUM_REQ,
    parameter int SIZE_DATA  = shf_arb_pkg::SIZE_DATA,
    parameter int SIZE_SHIFT = shf_arb_pkg::SIZE_SHIFT,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_data,
    input  logic [NUM_REQ*SIZE_SHIFT-1:0] i_req_shift,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [SIZE_DATA-1:0]          o_rsp_data,
    output logic [ID_W-1:0]               o_rsp_id,
    output logic                          o_rsp_sticky
);

    typedef struct packed {
        logic [SIZE_DATA-1:0]  data;
        logic [SIZE_SHIFT-1:0] shift;
        logic [ID_W-1:0]       id;
    } s1_t;

    // Pipeline state
    s1_t                  s1_q;
    logic                 s1_valid_q;
    logic [SIZE_DATA-1:0] s2_data_q;
    logic [ID_W-1:0]      s2_id_q;
    logic                 s2_valid_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;

    // Combinational helpers
    logic                 s2_adv;
    logic                 s1_adv;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_any;
    logic                 accept;
    int                   arb_idx;
    s1_t                  s1_d;
    logic [SIZE_DATA-1:0] shifted;

    assign s2_adv = !s2_valid_q || i_rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        arb_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            if (!gnt_any && i_req_valid[arb_idx]) begin
                gnt_any        = 1'b1;
                grant[arb_idx] = 1'b1;
                gnt_id         = ID_W'(arb_idx);
            end
        end
    end

    // Ready depends only on valids and pipeline occupancy, never on operands.
    assign o_req_ready = grant & {NUM_REQ{s1_adv}};
    assign accept      = gnt_any && s1_adv;

    // Operand mux and pointer advance for the granted requester.
    always_comb begin
        s1_d.data  = i_req_data[int'(gnt_id)*SIZE_DATA +: SIZE_DATA];
        s1_d.shift = i_req_shift[int'(gnt_id)*SIZE_SHIFT +: SIZE_SHIFT];
        s1_d.id    = gnt_id;
        rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    // S1 capture stage and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            rr_ptr_q   <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_q       <= s1_d;
            rr_ptr_q   <= rr_ptr_d;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    SHF_right #(
        .SIZE_DATA  (SIZE_DATA),
        .SIZE_SHIFT (SIZE_SHIFT)
    ) u_shf_right (
        .i_data  (s1_q.data),
        .i_shift (s1_q.shift),
        .o_data  (shifted)
    );

    // S2 result stage; holds its contents while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= shifted;
                s2_id_q   <= s1_q.id;
            end
        end
    end

`ifdef SHF_ARB_STICKY_EN
    logic [SIZE_DATA-1:0] sticky_mask;
    logic                 sticky_d;
    logic                 s2_sticky_q;

    // Mask of bit positions discarded by the shift; all ones when the
    // amount reaches or exceeds the operand width.
    always_comb begin
        sticky_mask = ~({SIZE_DATA{1'b1}} << s1_q.shift);
        sticky_d    = |(s1_q.data & sticky_mask);
    end

    // Sticky bit travels alongside the S2 result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_sticky_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            s2_sticky_q <= sticky_d;
        end
    end

    assign o_rsp_sticky = s2_sticky_q;
`else
    assign o_rsp_sticky = 1'b0;
`endif

    assign o_rsp_valid = s2_valid_q;
    assign o_rsp_data  = s2_data_q;
    assign o_rsp_id    = s2_id_q;

endmodule

`default_nettype wire

// File: tb/tb_shf_rr_arbiter.sv
// ============================================================================
// Module : tb_shf_rr_arbiter
// Brief  : Self-checking bench for shf_rr_arbiter with a transaction-level
//          reference model (pointer, in-flight queue with accept timestamps).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shf_rr_arbiter;

`ifdef SHF_ARB_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [19:0]  req_shift;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_sticky;

    shf_rr_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_data   (req_data),
        .i_req_shift  (req_shift),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .o_rsp_sticky (rsp_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sticky;
        int          id;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   ptr;
    int   cyc;
    int   checks;
    int   failures;
    int   accepts;
    int   mode;       // 0: drop valid after grant, 1: keep with new operand, 2: random
    int   last_gnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        for (int i = 0; i < 4; i++) begin
            if (req_valid[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic bit model_out_valid();
        return (q.size() > 0) && (cyc - q[0].acc >= 2);
    endfunction

    function automatic bit model_can_accept();
        return !(q.size() >= 2 && !(model_out_valid() && rsp_ready));
    endfunction

    task automatic set_req(input int k, input logic v, input logic [31:0] d, input logic [4:0] s);
        req_valid[k]        = v;
        req_data[k*32 +: 32] = d;
        req_shift[k*5 +: 5]  = s;
    endtask

    task automatic rand_req(input int k, input logic v);
        logic [4:0] s;
        case ($urandom_range(0, 3))
            0:       s = 5'd0;
            1:       s = 5'd31;
            default: s = 5'($urandom_range(0, 31));
        endcase
        set_req(k, v, $urandom, s);
    endtask

    // One clock: check outputs against the model, advance the model at the
    // edge, then update requester stimulus on the falling edge.
    task automatic step();
        int          k;
        bit          outv;
        bit          canacc;
        logic [3:0]  expr;
        logic [31:0] d;
        logic [4:0]  s;
        logic [63:0] lost;
        #1;
        k      = model_pick();
        canacc = model_can_accept();
        expr   = (k >= 0 && canacc) ? (4'b0001 << k) : 4'b0000;
        outv   = model_out_valid();
        check("req_ready", 64'(req_ready), 64'(expr));
        check("rsp_valid", 64'(rsp_valid), 64'(outv));
        if (outv) begin
            check("rsp_data", 64'(rsp_data), 64'(q[0].data));
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_sticky", 64'(rsp_sticky), 64'(q[0].sticky));
        end
        @(posedge clk);
        if (outv && rsp_ready) q.delete(0);
        last_gnt = -1;
        if (expr != 4'b0000) begin
            exp_t e;
            d     = req_data[k*32 +: 32];
            s     = req_shift[k*5 +: 5];
            lost  = 64'(d) & ((64'd1 << s) - 64'd1);
            e.data   = d >> s;
            e.sticky = STICKY_ON && (lost != 64'd0);
            e.id     = k;
            e.acc    = cyc;
            q.push_back(e);
            ptr      = (k + 1) % 4;
            accepts++;
            last_gnt = k;
        end
        cyc++;
        @(negedge clk);
        if (last_gnt >= 0) begin
            if (mode == 0)      req_valid[last_gnt] = 1'b0;
            else if (mode == 1) rand_req(last_gnt, 1'b1);
            else                rand_req(last_gnt, 1'($urandom_range(0, 1)));
        end
        if (mode == 2) begin
            for (int j = 0; j < 4; j++) begin
                if (!req_valid[j] && $urandom_range(0, 2) == 0) rand_req(j, 1'b1);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        accepts   = 0;
        ptr       = 0;
        cyc       = 0;
        mode      = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = '0;
        req_shift = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything quiet for three cycles.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_rsp_data", 64'(rsp_data), 64'd0);
            check("idle_rsp_id", 64'(rsp_id), 64'd0);
            check("idle_sticky", 64'(rsp_sticky), 64'd0);
            step();
        end

        // Single request from requester 1: two-cycle latency.
        mode = 0;
        set_req(1, 1'b1, 32'h8000_0001, 5'd4);
        step();
        step();
        #1;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_data", 64'(rsp_data), 64'h0800_0000);
        check("single_id", 64'(rsp_id), 64'd1);
        check("single_sticky", 64'(rsp_sticky), 64'(STICKY_ON));
        step();
        drain();

        // All requesters streaming with the consumer always ready.
        mode = 1;
        for (int k = 0; k < 4; k++) rand_req(k, 1'b1);
        for (int i = 0; i < 12; i++) step();
        drain();

        // Backpressure: only two entries may be accepted while stalled.
        mode      = 1;
        rsp_ready = 1'b0;
        rand_req(0, 1'b1);
        rand_req(2, 1'b1);
        accepts = 0;
        for (int i = 0; i < 5; i++) step();
        check("bp_accepts", 64'(accepts), 64'd2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        drain();

        // Shift corner cases.
        mode = 0;
        set_req(0, 1'b1, 32'h1234_5678, 5'd0);
        set_req(3, 1'b1, 32'hFFFF_FFFF, 5'd31);
        for (int i = 0; i < 3; i++) step();
        drain();

        // Randomised traffic with random consumer stalls.
        mode = 2;
        for (int i = 0; i < 400; i++) step();
        mode = 0;
        drain();
        drain();

        // Reset with both stages full: nothing emerges, pointer restarts at 0.
        mode      = 0;
        rsp_ready = 1'b0;
        rand_req(1, 1'b1);
        rand_req(2, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("full_before_rst", 64'(q.size()), 64'd2);
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        ptr = 0;
        cyc++;
        for (int i = 0; i < 2; i++) step();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) rand_req(k, 1'b1);
        #1;
        check("post_rst_grant", 64'(req_ready), 64'h1);
        step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shf_rr_arbiter.md
# shf_rr_arbiter

Shares one right barrel shifter (mantissa alignment datapath) between `NUM_REQ` requesters, such as the FPU alignment lanes of the FFT butterflies. It arbitrates round-robin with per-requester valid/ready handshakes and pipelines the granted operand through a capture stage and a result stage. It returns the shifted data, the requester ID and an optional sticky bit to a single downstream consumer.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `SIZE_DATA`, default 32: operand width.
- `SIZE_SHIFT`, default 5: shift-amount width.
- `ID_W`, default `$clog2(NUM_REQ)`: response ID width.
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: reset; one clock, synchronous, active-low.
- `i_req_valid`, input, `NUM_REQ`: request valid per requester.
- `o_req_ready`, output, `NUM_REQ`: request accepted this cycle (one-hot or zero).
- `i_req_data`, input, `NUM_REQ`×`SIZE_DATA`: operand per requester.
- `i_req_shift`, input, `NUM_REQ`×`SIZE_SHIFT`: right-shift amount per requester.
- `o_rsp_valid`, output, 1: response valid.
- `i_rsp_ready`, input, 1: consumer accepts response.
- `o_rsp_data`, output, `SIZE_DATA`: logically right-shifted operand, zero-filled.
- `o_rsp_id`, output, `ID_W`: index of the originating requester.
- `o_rsp_sticky`, output, 1: OR of all bits shifted out.

## Operation
- Two pipeline registers:
  - S1 (capture): data, shift, id, valid.
  - S2 (result): shifted data, sticky, id, valid.
- `s2_adv = !s2_valid | i_rsp_ready`.
- `s1_adv = !s1_valid | s2_adv`.
- Arbitration:
  - Search starts at `rr_ptr` and picks the first `i_req_valid[k]`.
  - `o_req_ready[k] = grant[k] & s1_adv`.
  - Ready never asserts for a non-valid requester.
  - Ready is a function of valids and pipeline state only. It is independent of data and shift inputs.
- On accept of requester k:
  - S1 loads request k.
  - `rr_ptr` becomes `(k+1) mod NUM_REQ`.
- No accept: `rr_ptr` holds.
- When S1 is valid and `s2_adv`:
  - S2 loads the shifter output of S1.
  - S1 is emptied unless a new accept reloads it in the same cycle.
- Shifter: combinational between S1 and S2; `out = data >> shift`.
  - If `2^SIZE_SHIFT > SIZE_DATA` and `shift ≥ SIZE_DATA`: out = 0 and sticky = |data.
- Requester protocol:
  - Once asserted, a requester holds valid and stable data/shift until its ready.
  - The arbiter does not check this.
- Response protocol:
  - `o_rsp_*` stay stable while `o_rsp_valid & !i_rsp_ready`.
  - Response order equals accept order.

## Timing
- Reset values:
  - `o_req_ready` = 0 combinationally while the pipeline holds no valid entries, until a request arrives.
  - `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_id`=0, `o_rsp_sticky`=0.
  - `rr_ptr`=0; S1 and S2 valid=0.
- Latency: an accept in cycle N gives `o_rsp_valid` in cycle N+2, if the consumer is ready.
- Throughput: one request per cycle sustained with `i_rsp_ready` held high.
- Backpressure:
  - With `i_rsp_ready`=0, at most 2 requests are held (S1 and S2). All `o_req_ready`=0 once both are full.
  - When `i_rsp_ready` rises, an accept happens in the same cycle.
- Simultaneous events:
  - A response handshake, an S1→S2 move and a new accept may all occur in one cycle with no bubble.
- Wrap-around: the pointer after requester `NUM_REQ-1` is 0.
- Reset mid-operation: in-flight entries are dropped with no response; state returns to reset values on the next edge.

## Configuration
- `SHF_ARB_STICKY_EN` defined:
  - Sticky = OR of the bits shifted out, computed in the S1→S2 path and registered in S2.
- `SHF_ARB_STICKY_EN` undefined:
  - No sticky logic; `o_rsp_sticky` is tied to 0.
  - Port list unchanged.

## Structure
- Shared package `shf_arb_pkg`:
  - Default localparams `NUM_REQ`, `SIZE_DATA`, `SIZE_SHIFT`.
  - Typedef `shf_req_t` {data, shift, id}.
  - Typedef `shf_rsp_t` {data, sticky, id}.
- Sub-module: one instance of the existing `SHF_right` as the shifter, with `SIZE_DATA`/`SIZE_SHIFT` passed through.
- Arbiter, pointer, pipeline registers and sticky mask: in this module.

## Test plan
- Reset, then idle: all outputs 0 and ready 0 for 3 cycles after `i_rst_n` rises.
- Single request: req1 data=0x8000_0001, shift=4, rsp always ready. Expect accept in cycle N; at N+2 `o_rsp_data`=0x0800_0000, id=1, sticky=1 (0 without the macro).
- All 4 requesters valid continuously, rsp ready. Expect grants 0,1,2,3,0,… one per cycle and ids in the same order.
- Backpressure: `i_rsp_ready`=0 for 5 cycles with req0 and req2 streaming. Expect exactly 2 accepts, then ready 0 and the response held stable. On release, no bubble and order preserved.
- Shift corner cases: shift=0 gives output = data and sticky=0; shift=31 on 0xFFFF_FFFF gives 0x1, sticky=1.
- Reset asserted with S1 and S2 full: no response is emitted, `rr_ptr` returns to 0, and the next grant goes to requester 0.
